// File: rtl/button_conditioner.sv
// Push-button front end: synchronises raw levels, debounces them on a shared
// 1 ms tick, and emits press/release pulses plus auto-repeat step pulses.
module button_conditioner #(
  parameter int                 N_BTN              = 3,
  parameter int                 ACTIVE_LOW         = 0,
  parameter int                 TICK_DIV           = 50000,
  parameter int                 DEBOUNCE_TICKS     = 20,
  parameter int                 REPEAT_DELAY_TICKS = 500,
  parameter int                 REPEAT_RATE_TICKS  = 100,
  parameter logic [N_BTN-1:0]   REPEAT_MASK        = 3'b011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_step,
  output logic             tick
);

  localparam logic [N_BTN-1:0] POL       = (ACTIVE_LOW != 0) ? {N_BTN{1'b1}} : {N_BTN{1'b0}};
  localparam logic [15:0]      TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [7:0]       DEB_LAST  = 8'(DEBOUNCE_TICKS - 1);
  localparam logic [11:0]      DLY_LAST  = 12'(REPEAT_DELAY_TICKS - 1);
  localparam logic [11:0]      RATE_LAST = 12'(REPEAT_RATE_TICKS - 1);

  typedef enum logic [1:0] {R_IDLE, R_DELAY, R_RATE} rep_state_e;

  logic [15:0]      cnt;
  logic [N_BTN-1:0] sync_p0, sync_p1, s;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == TICK_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  assign tick = (cnt == TICK_LAST);

  // Stage p0/p1: two-flop synchroniser; reset loads the pin's idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= POL;
      sync_p1 <= POL;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  assign s = sync_p1 ^ POL;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [7:0] dcnt;
    logic       lvl, lvl_d, press, rel, rep;

    // Any cycle where the input agrees with the accepted level restarts the interval.
    always_ff @(posedge clk) begin
      if (rst) begin
        lvl  <= 1'b0;
        dcnt <= '0;
      end else if (s[i] == lvl) begin
        dcnt <= '0;
      end else if (tick) begin
        if (dcnt == DEB_LAST) begin
          lvl  <= s[i];
          dcnt <= '0;
        end else begin
          dcnt <= dcnt + 8'd1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        lvl_d <= 1'b0;
        press <= 1'b0;
        rel   <= 1'b0;
      end else begin
        lvl_d <= lvl;
        press <= lvl & ~lvl_d;
        rel   <= ~lvl & lvl_d;
      end
    end

    if (REPEAT_MASK[i]) begin : g_rep
      rep_state_e  state, state_nxt;
      logic [11:0] rcnt, rcnt_nxt;
      logic        rep_nxt;

      always_ff @(posedge clk) begin
        if (rst) begin
          state <= R_IDLE;
          rcnt  <= '0;
          rep   <= 1'b0;
        end else begin
          state <= state_nxt;
          rcnt  <= rcnt_nxt;
          rep   <= rep_nxt;
        end
      end

      // A dropped level wins over a due repeat, so release never meets a repeat.
      always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        rep_nxt   = 1'b0;
        case (state)
          R_IDLE: begin
            if (press && lvl) begin
              state_nxt = R_DELAY;
              rcnt_nxt  = '0;
            end
          end
          R_DELAY: begin
            if (!lvl) begin
              state_nxt = R_IDLE;
            end else if (tick) begin
              if (rcnt == DLY_LAST) begin
                rep_nxt   = 1'b1;
                rcnt_nxt  = '0;
                state_nxt = R_RATE;
              end else begin
                rcnt_nxt = rcnt + 12'd1;
              end
            end
          end
          R_RATE: begin
            if (!lvl) begin
              state_nxt = R_IDLE;
            end else if (tick) begin
              if (rcnt == RATE_LAST) begin
                rep_nxt  = 1'b1;
                rcnt_nxt = '0;
              end else begin
                rcnt_nxt = rcnt + 12'd1;
              end
            end
          end
          default: state_nxt = R_IDLE;
        endcase
      end
    end else begin : g_norep
      assign rep = 1'b0;
    end

    assign btn_level[i]   = lvl;
    assign btn_press[i]   = press;
    assign btn_release[i] = rel;
    assign btn_step[i]    = press | rep;
  end

endmodule
